// File: rtl/pix_pkg.sv
// Shared pixel-link definitions: framer FSM encoding and the byte values
// that give 0x00 its meaning as the frame marker on the serial line.
package pix_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HDR      = 3'd1,
      VRES     = 3'd2,
      HRES     = 3'd3,
      PIX_WAIT = 3'd4,
      PIX_SEND = 3'd5,
      FIN      = 3'd6
   } pix_state_e;

   localparam logic [7:0] FRAME_MARKER = 8'h00;
   localparam logic [7:0] ZERO_SUBST   = 8'h01;

   // Pixels must never look like a frame marker to the receiver.
   function automatic logic [7:0] subst_pixel(input logic [7:0] b);
      logic [7:0] r;
      if (b == FRAME_MARKER) begin
         r = ZERO_SUBST;
      end else begin
         r = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: a load while idle starts a byte on the next edge;
// complete pulses for one cycle once the stop bit has fully elapsed.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] data,
   input  logic       load,
   output logic       tx,
   output logic       idle,
   output logic       complete
);

   localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

   logic          active_q, active_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          complete_q, complete_d;

   // Bit sequencing: index 0 is the start bit, 1..8 data, 9 the stop bit.
   always_comb begin
      active_d   = active_q;
      bit_idx_d  = bit_idx_q;
      clk_cnt_d  = clk_cnt_q;
      shreg_d    = shreg_q;
      tx_d       = tx_q;
      complete_d = 1'b0;
      if (!active_q) begin
         if (load) begin
            active_d  = 1'b1;
            bit_idx_d = 4'd0;
            clk_cnt_d = '0;
            shreg_d   = data;
            tx_d      = 1'b0;
         end else begin
            tx_d = 1'b1;
         end
      end else if (clk_cnt_q == LAST) begin
         clk_cnt_d = '0;
         if (bit_idx_q == 4'd9) begin
            active_d   = 1'b0;
            complete_d = 1'b1;
            tx_d       = 1'b1;
         end else if (bit_idx_q == 4'd8) begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = 1'b1;
         end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
         end
      end else begin
         clk_cnt_d = clk_cnt_q + CW'(1);
      end
   end

   // Serializer state; the line idles high straight out of reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         active_q   <= 1'b0;
         bit_idx_q  <= 4'd0;
         clk_cnt_q  <= '0;
         shreg_q    <= 8'h00;
         tx_q       <= 1'b1;
         complete_q <= 1'b0;
      end else begin
         active_q   <= active_d;
         bit_idx_q  <= bit_idx_d;
         clk_cnt_q  <= clk_cnt_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
         complete_q <= complete_d;
      end
   end

   assign tx       = tx_q;
   assign idle     = ~active_q;
   assign complete = complete_q;

endmodule

// File: rtl/pix_tx_framer.sv
// Frame builder: sends 0x00, vres, hres and then vres*hres pixel bytes over
// a UART line, substituting 0x00 pixels so the marker stays unique.
module pix_tx_framer
   import pix_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       start,
   input  logic [7:0] img_hres,
   input  logic [7:0] img_vres,
   input  logic [7:0] pix_data,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   pix_state_e  state_q, state_d;
   logic [7:0]  vres_q, vres_d;
   logic [7:0]  hres_q, hres_d;
   logic [15:0] cnt_q, cnt_d;
   logic        load_q, load_d;
   logic [7:0]  byte_q, byte_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ready_q, ready_d;

   logic        ser_load_s;
   logic [7:0]  ser_data_s;
   logic        ser_tx_s;
   logic        ser_idle_s;
   logic        ser_complete_s;
   logic        xfer_s;

   assign xfer_s = (state_q == PIX_WAIT) && ready_q && pix_valid && ser_idle_s;

   // Header bytes go through a register; pixels load on the handshake itself
   // so back-to-back pixels keep the same two-cycle gap as the header.
   assign ser_load_s = load_q | xfer_s;
   assign ser_data_s = xfer_s ? subst_pixel(pix_data) : byte_q;

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .data     (ser_data_s),
      .load     (ser_load_s),
      .tx       (ser_tx_s),
      .idle     (ser_idle_s),
      .complete (ser_complete_s)
   );

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = HDR;
            else       state_d = IDLE;
         end
         HDR: begin
            if (ser_complete_s) state_d = VRES;
            else                state_d = HDR;
         end
         VRES: begin
            if (ser_complete_s) state_d = HRES;
            else                state_d = VRES;
         end
         HRES: begin
            if (!ser_complete_s)                          state_d = HRES;
            else if ((vres_q == 8'd0) || (hres_q == 8'd0)) state_d = FIN;
            else                                          state_d = PIX_WAIT;
         end
         PIX_WAIT: begin
            if (xfer_s) state_d = PIX_SEND;
            else        state_d = PIX_WAIT;
         end
         PIX_SEND: begin
            if (!ser_complete_s)     state_d = PIX_SEND;
            else if (cnt_q != 16'd0) state_d = PIX_WAIT;
            else                     state_d = FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath logic; each header byte is queued as its state is entered.
   always_comb begin
      vres_d  = vres_q;
      hres_d  = hres_q;
      cnt_d   = cnt_q;
      load_d  = 1'b0;
      byte_d  = byte_q;
      if ((state_q == IDLE) && start) begin
         vres_d = img_vres;
         hres_d = img_hres;
         cnt_d  = {8'h00, img_vres} * {8'h00, img_hres};
         load_d = 1'b1;
         byte_d = FRAME_MARKER;
      end else if ((state_q == HDR) && ser_complete_s) begin
         load_d = 1'b1;
         byte_d = vres_q;
      end else if ((state_q == VRES) && ser_complete_s) begin
         load_d = 1'b1;
         byte_d = hres_q;
      end else if (xfer_s) begin
         cnt_d = cnt_q - 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
      busy_d  = (state_d != IDLE) && (state_d != FIN);
      done_d  = (state_d == FIN);
      ready_d = (state_d == PIX_WAIT);
   end

   // Datapath and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vres_q  <= 8'h00;
         hres_q  <= 8'h00;
         cnt_q   <= 16'd0;
         load_q  <= 1'b0;
         byte_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         vres_q  <= vres_d;
         hres_q  <= hres_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         byte_q  <= byte_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign tx        = ser_tx_s;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pix_ready = ready_q;

endmodule

// File: tb/tb_pix_tx_framer.sv
// Directed bench for pix_tx_framer at 4 clocks per bit, with a line decoder
// and a pixel source that honours the valid/ready handshake.
module tb_pix_tx_framer;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] img_hres = 8'h00;
   logic [7:0] img_vres = 8'h00;
   logic [7:0] pix_data = 8'h00;
   logic       pix_valid = 1'b0;
   logic       pix_ready, tx, busy, done;

   int checks = 0;
   int errors = 0;

   pix_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
      .CLK(clk), .RST_N(rst_n), .start(start), .img_hres(img_hres), .img_vres(img_vres),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .tx(tx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Line decoder: samples each bit 2.5 cycles into it.
   logic [7:0] rx[$];
   int         frame_err = 0;
   bit         m_act = 1'b0;
   int         m_cnt, m_bit;
   logic [7:0] m_sh;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (tx === 1'b0) begin
            m_act = 1'b1;
            m_cnt = 0;
         end
      end else begin
         m_cnt = m_cnt + 1;
         if (m_cnt >= 2 && ((m_cnt - 2) % CPB) == 0) begin
            m_bit = (m_cnt - 2) / CPB;
            if (m_bit == 0) begin
               if (tx !== 1'b0) begin
                  frame_err++;
                  m_act = 1'b0;
               end
            end else if (m_bit <= 8) begin
               m_sh[m_bit-1] = tx;
            end else begin
               if (tx !== 1'b1) frame_err++;
               rx.push_back(m_sh);
               m_act = 1'b0;
            end
         end
      end
   end

   // Pixel source; hold_after limits how many pixels are offered.
   logic [7:0] src[$];
   int         src_idx = 0;
   int         hold_after = 1000;
   bit         xfer_pend = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         xfer_pend = 1'b0;
         pix_valid = 1'b0;
      end else begin
         if (xfer_pend) src_idx++;
         pix_valid = (src_idx < src.size()) && (src_idx < hold_after);
         pix_data  = (src_idx < src.size()) ? src[src_idx] : 8'h00;
         xfer_pend = pix_valid && pix_ready;
      end
   end

   task automatic do_start(input logic [7:0] v, input logic [7:0] h);
      @(negedge clk);
      img_vres = v;
      img_hres = h;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic run_until_done(input int limit, output int dcyc, output bit busy_ok,
                                 output bit ready_seen, output logic busy_at_done);
      dcyc = -1;
      busy_ok = 1'b1;
      ready_seen = 1'b0;
      busy_at_done = 1'bx;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (pix_ready === 1'b1) ready_seen = 1'b1;
         if (done === 1'b1) begin
            dcyc = i;
            busy_at_done = busy;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic count_done(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done === 1'b1) c++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
      checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", pix_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [7:0] exp[$];
      logic [7:0] got;
      int dcyc, extra;
      bit busy_ok, rdy;
      logic bad;
      rx.delete(); src = '{8'h11, 8'h22, 8'h33, 8'h44}; src_idx = 0; hold_after = 1000;
      do_start(8'd2, 8'd2);
      run_until_done(600, dcyc, busy_ok, rdy, bad);
      checks++; if (dcyc !== 294) begin errors++; $display("FAIL basic_done_cycle got %0d expected 294", dcyc); end
      checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL basic_busy_held got %b expected 1", busy_ok); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b expected 0", bad); end
      count_done(60, extra);
      checks++; if (extra !== 0) begin errors++; $display("FAIL basic_extra_done got %0d expected 0", extra); end
      exp = '{8'h00, 8'h02, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL basic_len got %0d expected %0d", rx.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_zero_subst;
      logic [7:0] exp[$];
      logic [7:0] got;
      int dcyc;
      bit busy_ok, rdy;
      logic bad;
      rx.delete(); src = '{8'h00, 8'hFF, 8'h00}; src_idx = 0; hold_after = 1000;
      do_start(8'd1, 8'd3);
      run_until_done(600, dcyc, busy_ok, rdy, bad);
      checks++; if (dcyc < 0) begin errors++; $display("FAIL subst_done got none expected pulse"); end
      exp = '{8'h00, 8'h01, 8'h03, 8'h01, 8'hFF, 8'h01};
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL subst_len got %0d expected %0d", rx.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL subst_byte%0d got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_zero_dim;
      logic [7:0] exp[$];
      logic [7:0] got;
      int dcyc;
      bit busy_ok, rdy;
      logic bad;
      rx.delete(); src = '{8'h99, 8'h98}; src_idx = 0; hold_after = 1000;
      do_start(8'd0, 8'd5);
      run_until_done(400, dcyc, busy_ok, rdy, bad);
      checks++; if (dcyc !== 126) begin errors++; $display("FAIL zdim_done_cycle got %0d expected 126", dcyc); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL zdim_ready_seen got %b expected 0", rdy); end
      exp = '{8'h00, 8'h00, 8'h05};
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL zdim_len got %0d expected %0d", rx.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL zdim_byte%0d got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_stall;
      logic [7:0] exp[$];
      logic [7:0] got;
      int dcyc, w;
      bit busy_ok, rdy, stall_ok;
      logic bad;
      rx.delete(); src = '{8'h55, 8'hAA}; src_idx = 0; hold_after = 1;
      do_start(8'd1, 8'd2);
      w = 0;
      while (!(src_idx == 1 && pix_ready === 1'b1) && w < 600) begin
         @(negedge clk);
         w++;
      end
      checks++; if (w >= 600) begin errors++; $display("FAIL stall_reach_wait got timeout expected pix_ready"); end
      stall_ok = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b1 || done !== 1'b0) stall_ok = 1'b0;
      end
      checks++; if (stall_ok !== 1'b1) begin errors++; $display("FAIL stall_line_idle got %b expected 1", stall_ok); end
      hold_after = 1000;
      run_until_done(400, dcyc, busy_ok, rdy, bad);
      checks++; if (dcyc < 0) begin errors++; $display("FAIL stall_done got none expected pulse"); end
      exp = '{8'h00, 8'h01, 8'h02, 8'h55, 8'hAA};
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL stall_len got %0d expected %0d", rx.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL stall_byte%0d got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_start_ignored;
      logic [7:0] exp[$];
      logic [7:0] got;
      int dcyc, extra, total;
      bit busy_ok, rdy;
      logic bad;
      rx.delete(); src = '{8'h42, 8'h43, 8'h44}; src_idx = 0; hold_after = 1000;
      do_start(8'd1, 8'd1);
      repeat (60) @(negedge clk);
      img_vres = 8'd3; img_hres = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_until_done(400, dcyc, busy_ok, rdy, bad);
      count_done(300, extra);
      total = ((dcyc > 0) ? 1 : 0) + extra;
      checks++; if (total !== 1) begin errors++; $display("FAIL ignore_done_count got %0d expected 1", total); end
      exp = '{8'h00, 8'h01, 8'h01, 8'h42};
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL ignore_len got %0d expected %0d", rx.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL ignore_byte%0d got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_reset_abort;
      logic [7:0] exp[$];
      logic [7:0] got;
      int dcyc, dcnt;
      bit busy_ok, rdy;
      logic bad;
      rx.delete(); src = '{8'h10, 8'h20, 8'h30, 8'h40}; src_idx = 0; hold_after = 1000;
      do_start(8'd2, 8'd2);
      repeat (50) @(negedge clk);
      checks++; if (tx !== m_sh[5] && tx !== 1'b0 && tx !== 1'b1) begin errors++; $display("FAIL abort_pre_tx got %b expected 0/1", tx); end
      rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
      count_done(3, dcnt);
      checks++; if (dcnt !== 0) begin errors++; $display("FAIL abort_done got %0d expected 0", dcnt); end
      rx.delete(); src = '{8'h7E}; src_idx = 0;
      @(negedge clk);
      rst_n = 1'b1; img_vres = 8'd1; img_hres = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_first_edge_busy got %b expected 1", busy); end
      run_until_done(400, dcyc, busy_ok, rdy, bad);
      checks++; if (dcyc < 0) begin errors++; $display("FAIL abort_refr_done got none expected pulse"); end
      exp = '{8'h00, 8'h01, 8'h01, 8'h7E};
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL abort_len got %0d expected %0d", rx.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL abort_byte%0d got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_line_integrity;
      checks++; if (frame_err !== 0) begin errors++; $display("FAIL line_framing got %0d expected 0", frame_err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_subst();
      test_zero_dim();
      test_stall();
      test_start_ignored();
      test_reset_abort();
      test_line_integrity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
